// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the fetch requester, data requester and RAM-side
// signals around the memory arbiter.
//   slave  : the arbiter itself (takes requests and RAM responses, drives
//            stalls, loads and RAM strobes).
//   master : the surrounding environment (caches and RAM model).
// Signals:
//   iREN/iaddr -> iwait/iload            fetch requester
//   dREN/dWEN/daddr/dstore -> dwait/dload data requester
//   ramREN/ramWEN/ramaddr/ramstore       RAM command
//   ramload/ramready                     RAM response
//   err                                  one-cycle timeout pulse
interface mem_arbiter_if #(
  parameter int WORD_W = 32
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic              ramready;
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the instruction-fetch requester and
// the data requester. Data wins ties unless it has already taken STARVE_LIMIT
// consecutive grants while fetch was waiting. Each grant is bounded by TIMEOUT
// cycles; a forced release pulses err.
// Ports:
//   CLK  in  clock, rising edge
//   RST  in  asynchronous active-high reset
//   bus  mem_arbiter_if.slave (requesters, RAM command/response, err)
// Parameters:
//   WORD_W        address/data width
//   STARVE_LIMIT  data grants allowed in a row while fetch waits (0 = pure data priority)
//   TIMEOUT       max cycles in a grant state (>= 2)
module mem_arbiter #(
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  bus
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [WORD_W-1:0] ZERO_W = '0;

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic dreq;
  logic starve;
  logic tmo_hit;

  // Saturating increment of the data-grant streak.
  function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
    return (s == SW'(STARVE_LIMIT)) ? s : s + SW'(1);
  endfunction

  assign dreq    = bus.dREN | bus.dWEN;
  assign starve  = (STARVE_LIMIT != 0) && (streak_q == SW'(STARVE_LIMIT));
  assign tmo_hit = (tcnt_q == TW'(TIMEOUT - 1)) && !bus.ramready;

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    tcnt_d       = tcnt_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = ZERO_W;
    bus.ramstore = ZERO_W;
    bus.iload    = ZERO_W;
    bus.dload    = ZERO_W;
    bus.err      = 1'b0;
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq;

    case (state_q)
      IDLE: begin
        // Grants only start from IDLE, so there is always a bubble between grants.
        tcnt_d = '0;
        if (dreq && bus.iREN)  state_d = starve ? IGRANT : DGRANT;
        else if (dreq)         state_d = DGRANT;
        else if (bus.iREN)     state_d = IGRANT;
      end

      DGRANT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (!dreq) begin
          // Abort: requester withdrew, RAM sees nothing, streak untouched.
          state_d = IDLE;
        end else begin
          bus.ramWEN   = bus.dWEN;
          bus.ramREN   = bus.dREN & ~bus.dWEN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          if (bus.ramready || tmo_hit) begin
            bus.dwait = 1'b0;
            bus.dload = bus.ramready ? bus.ramload : ZERO_W;
            bus.err   = tmo_hit;
            state_d   = IDLE;
            streak_d  = bus.iREN ? streak_inc(streak_q) : '0;
          end
        end
      end

      IGRANT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (bus.ramready || tmo_hit) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramready ? bus.ramload : ZERO_W;
            bus.err   = tmo_hit;
            state_d   = IDLE;
            streak_d  = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      tcnt_q   <= tcnt_d;
    end
  end

endmodule
